// File: rtl/mdu.sv
`default_nettype none
//==============================================================================
// Module      : mdu
// Description : Iterative multiply/divide unit with HI/LO result registers.
//               MULT/MULTU use shift-add on a 64-bit accumulator; DIV/DIVU use
//               restoring division (remainder in the upper half of the same
//               accumulator, dividend/quotient in the lower half). Signed
//               operations run on magnitudes, and the signs are applied in a
//               final FIX cycle. MTHI/MTLO write HI/LO directly while idle.
//
// Ports       : clk    - clock, all state updates on posedge
//               rst_n  - asynchronous active-low reset
//               start  - launch op (sampled only when busy=0)
//               op     - 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//               A, B   - rs / rt operands
//               hi_wr  - MTHI strobe (HI <= wd), idle only
//               lo_wr  - MTLO strobe (LO <= wd), idle only
//               wd     - MTHI/MTLO data
//               busy   - operation in progress
//               HI, LO - result registers
//
// Options     : MDU_FAST_MUL_EN - when defined, MULT/MULTU finish with a
//               single-cycle combinational multiply (busy high 1 cycle);
//               divides keep the iterative 33-cycle path.
//
// Revision    : 1.0 - initial release
//==============================================================================
module mdu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            hi_wr,
    input  logic            lo_wr,
    input  logic [XLEN-1:0] wd,
    output logic            busy,
    output logic [XLEN-1:0] HI,
    output logic [XLEN-1:0] LO
);

    localparam int CW = $clog2(XLEN);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;
`ifdef MDU_FAST_MUL_EN
    localparam logic [1:0] c_FAST = 2'd3;
`endif

    localparam logic [CW-1:0] c_LAST_STEP = CW'(XLEN - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic [CW-1:0]     r_cnt;
    logic              r_div;     // latched op[1]: divide vs multiply
    logic              r_sa;      // sign of A (signed ops only)
    logic              r_sb;      // sign of B (signed ops only)
    logic [XLEN-1:0]   r_a;       // |A|: multiplicand, and source of HI on /0
    logic [XLEN-1:0]   r_b;       // |B|: divisor
    logic [2*XLEN-1:0] r_acc;     // mul: {product hi, multiplier/product lo}
                                  // div: {remainder, dividend/quotient}
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;

    logic              w_sa;
    logic              w_sb;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_next;
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN:0]     w_rem_sub;
    logic [2*XLEN-1:0] w_div_next;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_hi_res;
    logic [XLEN-1:0]   w_lo_res;

    // Magnitudes: negating 0x80000000 yields 0x80000000, which is the
    // correct unsigned magnitude, so no special case is needed.
    assign w_sa    = op[0] & A[XLEN-1];
    assign w_sb    = op[0] & B[XLEN-1];
    assign w_mag_a = w_sa ? -A : A;
    assign w_mag_b = w_sb ? -B : B;

    // Shift-add step: the carry out of the upper-half add becomes the new
    // MSB as the accumulator shifts right.
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_a} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

    // Restoring step: the remainder stays below the divisor, so the shifted
    // value fits 33 bits and bit 32 of the difference is a clean borrow.
    assign w_rem_sh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_rem_sub  = w_rem_sh - {1'b0, r_b};
    assign w_div_next = w_rem_sub[XLEN] ? {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                        : {w_rem_sub[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

    // Sign fix-up applied during the FIX cycle.
    always_comb begin
        w_prod   = (r_sa ^ r_sb) ? -r_acc : r_acc;
        w_hi_res = w_prod[2*XLEN-1:XLEN];
        w_lo_res = w_prod[XLEN-1:0];
        if (r_div) begin
            if (r_b == '0) begin
                // Divide by zero: all-ones quotient, HI gets the original A.
                w_lo_res = '1;
                w_hi_res = r_sa ? -r_a : r_a;
            end else begin
                w_lo_res = (r_sa ^ r_sb) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
                w_hi_res = r_sa ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
            end
        end
    end

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fast_ax;
    logic [2*XLEN-1:0] w_fast_bx;
    logic [2*XLEN-1:0] w_fast_prod;

    // Sign-extend for MULT, zero-extend for MULTU; the low 64 bits of the
    // product are then correct for both.
    assign w_fast_ax   = {{XLEN{op[0] & A[XLEN-1]}}, A};
    assign w_fast_bx   = {{XLEN{op[0] & B[XLEN-1]}}, B};
    assign w_fast_prod = w_fast_ax * w_fast_bx;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_next = c_CALC;
`ifdef MDU_FAST_MUL_EN
                    if (!op[1]) begin
                        w_next = c_FAST;
                    end
`endif
                end
            end
            c_CALC: begin
                if (r_cnt == c_LAST_STEP) begin
                    w_next = c_FIX;
                end
            end
            c_FIX:   w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    // Datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_div <= 1'b0;
            r_sa  <= 1'b0;
            r_sb  <= 1'b0;
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (hi_wr) begin
                        r_hi <= wd;
                    end
                    if (lo_wr) begin
                        r_lo <= wd;
                    end
                    if (start) begin
                        r_cnt <= '0;
                        r_div <= op[1];
                        r_sa  <= w_sa;
                        r_sb  <= w_sb;
                        r_a   <= w_mag_a;
                        r_b   <= w_mag_b;
                        r_acc <= {{XLEN{1'b0}}, (op[1] ? w_mag_a : w_mag_b)};
`ifdef MDU_FAST_MUL_EN
                        // Result overrides a same-cycle MTHI/MTLO.
                        if (!op[1]) begin
                            r_hi <= w_fast_prod[2*XLEN-1:XLEN];
                            r_lo <= w_fast_prod[XLEN-1:0];
                        end
`endif
                    end
                end
                c_CALC: begin
                    r_cnt <= r_cnt + 1'b1;
                    r_acc <= r_div ? w_div_next : w_mul_next;
                end
                c_FIX: begin
                    r_hi <= w_hi_res;
                    r_lo <= w_lo_res;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (r_state != c_IDLE);
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
//==============================================================================
// Module      : tb_mdu
// Description : Self-checking bench for mdu: directed vector table, MTHI/MTLO,
//               busy-time start/write masking, async reset mid-operation and
//               random operations against a 64-bit arithmetic reference.
//               Honours MDU_FAST_MUL_EN for multiply latency.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_mdu;

`ifdef MDU_FAST_MUL_EN
    localparam bit c_FAST = 1'b1;
`else
    localparam bit c_FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        hi_wr;
    logic        lo_wr;
    logic [31:0] wd;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks   = 0;
    int failures = 0;

    mdu #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .hi_wr (hi_wr),
        .lo_wr (lo_wr),
        .wd    (wd),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_busy(input logic [1:0] o);
        return (c_FAST && !o[1]) ? 1 : 33;
    endfunction

    // Reference: plain 64-bit arithmetic; returns {HI, LO}.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint x;
        longint y;
        longint q;
        longint r;
        logic [63:0] p;
        if (o[0]) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'b0, a});
            y = longint'({32'b0, b});
        end
        if (!o[1]) begin
            p = x * y;
            return p;
        end
        if (b == 32'h0) begin
            return {a, 32'hFFFFFFFF};
        end
        q = x / y;
        r = x % y;
        p = {r[31:0], q[31:0]};
        return p;
    endfunction

    // Launch one op and wait for busy to drop; returns busy-high cycles.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, output int ncyc);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        @(negedge clk);
        start = 1'b0;
        ncyc  = 0;
        while (busy === 1'b1 && ncyc < 100) begin
            ncyc++;
            @(negedge clk);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h00000000;
            1:       return 32'h80000000;
            2:       return 32'hFFFFFFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] exp;

        vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[4]  = '{2'b10, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF};
        vecs[5]  = '{2'b11, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[6]  = '{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[7]  = '{2'b00, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F};
        vecs[8]  = '{2'b10, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
        vecs[9]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[10] = '{2'b10, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};

        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        A     = '0;
        B     = '0;
        hi_wr = 1'b0;
        lo_wr = 1'b0;
        wd    = '0;

        repeat (2) @(negedge clk);
        check("reset_busy", {63'b0, busy}, 64'd0);
        check("reset_hi", {32'b0, HI}, 64'd0);
        check("reset_lo", {32'b0, LO}, 64'd0);
        rst_n = 1'b1;

        // Directed vectors.
        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, n);
            check($sformatf("vec%0d_busy", i), 64'(n), 64'(exp_busy(vecs[i].op)));
            check($sformatf("vec%0d_hi", i), {32'b0, HI}, {32'b0, vecs[i].hi});
            check($sformatf("vec%0d_lo", i), {32'b0, LO}, {32'b0, vecs[i].lo});
        end

        // MTHI / MTLO while idle.
        @(negedge clk);
        hi_wr = 1'b1;
        wd    = 32'h12345678;
        @(negedge clk);
        hi_wr = 1'b0;
        lo_wr = 1'b1;
        wd    = 32'h9ABCDEF0;
        @(negedge clk);
        lo_wr = 1'b0;
        check("mthi", {32'b0, HI}, 64'h12345678);
        check("mtlo", {32'b0, LO}, 64'h9ABCDEF0);

        // Start together with MTHI/MTLO: write first, result overwrites later.
        start = 1'b1;
        op    = 2'b00;
        A     = 32'd2;
        B     = 32'd3;
        hi_wr = 1'b1;
        lo_wr = 1'b1;
        wd    = 32'hAAAA5555;
        @(negedge clk);
        start = 1'b0;
        hi_wr = 1'b0;
        lo_wr = 1'b0;
        check("simul_wr_hi", {32'b0, HI}, c_FAST ? 64'h0 : 64'hAAAA5555);
        check("simul_wr_lo", {32'b0, LO}, c_FAST ? 64'h6 : 64'hAAAA5555);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("simul_busy", 64'(n), 64'(exp_busy(2'b00)));
        check("simul_res_hi", {32'b0, HI}, 64'h0);
        check("simul_res_lo", {32'b0, LO}, 64'h6);

        // Start and MTHI/MTLO on cycle 10 of a DIVU are ignored.
        start = 1'b1;
        op    = 2'b10;
        A     = 32'd1000;
        B     = 32'd7;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (n == 10) begin
                start = 1'b1;
                op    = 2'b00;
                A     = 32'd5;
                B     = 32'd5;
                hi_wr = 1'b1;
                lo_wr = 1'b1;
                wd    = 32'hDEADBEEF;
            end else begin
                start = 1'b0;
                hi_wr = 1'b0;
                lo_wr = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        hi_wr = 1'b0;
        lo_wr = 1'b0;
        check("busy_ign_cycles", 64'(n), 64'd33);
        check("busy_ign_hi", {32'b0, HI}, 64'd6);
        check("busy_ign_lo", {32'b0, LO}, 64'd142);
        @(negedge clk);
        check("busy_ign_nolaunch", {63'b0, busy}, 64'd0);

        // Async reset in the middle of an operation.
        start = 1'b1;
        op    = 2'b10;
        A     = 32'd1000;
        B     = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst_pre_busy", {63'b0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {63'b0, busy}, 64'd0);
        check("midrst_hi", {32'b0, HI}, 64'd0);
        check("midrst_lo", {32'b0, LO}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(2'b01, 32'hFFFFFFFD, 32'h00000007, n);
        check("postrst_busy", 64'(n), 64'(exp_busy(2'b01)));
        check("postrst_hilo", {HI, LO}, 64'hFFFFFFFF_FFFFFFEB);

        // Random operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            ro  = 2'($urandom_range(0, 3));
            ra  = pick();
            rb  = pick();
            exp = model(ro, ra, rb);
            run_op(ro, ra, rb, n);
            check($sformatf("rnd%0d_busy op=%0d a=%h b=%h", i, ro, ra, rb), 64'(n), 64'(exp_busy(ro)));
            check($sformatf("rnd%0d_hilo op=%0d a=%h b=%h", i, ro, ra, rb), {HI, LO}, exp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mdu.md
Name: mdu

Overview:
- Iterative multiply/divide unit; downstream consumer of the register file read ports (operands come from RD1/RD2 via the A/B operand latches).
- Executes MULT/MULTU/DIV/DIVU into internal HI/LO registers.
- Executes MTHI/MTLO writes directly.
- The multi-cycle controller stalls on `busy`. MFHI/MFLO read HI/LO back through the write-back path into RF WD.

Parameters:
- XLEN, 32, operand and HI/LO width; only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  launch operation; sampled only when busy=0.
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- A  in  32  operand rs (multiplicand/dividend).
- B  in  32  operand rt (multiplier/divisor).
- hi_wr  in  1  MTHI: HI <= wd.
- lo_wr  in  1  MTLO: LO <= wd.
- wd  in  32  MTHI/MTLO data.
- busy  out  1  operation in progress.
- HI  out  32  HI register (product high / remainder).
- LO  out  32  LO register (product low / quotient).

Behaviour:
- Reset (async, rst_n=0): state IDLE, busy=0, HI=0, LO=0, iteration counter=0. Applies mid-operation; the partial result is discarded.
- States: IDLE -> CALC (32 cycles) -> FIX (1 cycle) -> IDLE.
- IDLE, start=1 at posedge:
  - Latch A, B and op.
  - Signed ops latch the magnitudes plus the sign bits.
  - Counter=0, busy=1 from the next cycle.
- CALC, one step per cycle:
  - Multiply: shift-add, 64-bit accumulator.
  - Divide: restoring; 32-bit remainder, 32-bit quotient.
  - Counter increments each step; leave CALC after step 31.
- FIX:
  - Apply signs.
    - Signed product: negate if sign(A)^sign(B).
    - Quotient: negate if sign(A)^sign(B).
    - Remainder: takes sign(A).
  - Write HI/LO at the end of FIX; busy=0 in the following cycle.
- Latency: busy high exactly 33 cycles. HI/LO are valid in the first cycle with busy=0.
- start while busy=1: ignored; operands are not relatched.
- hi_wr/lo_wr:
  - busy=0: take effect at posedge.
  - busy=1: ignored.
  - Simultaneous start with hi_wr/lo_wr in IDLE: the write happens, then the operation launches. Its result later overwrites HI/LO.
- Divide by zero (B=0, DIVU or DIV):
  - LO=0xFFFFFFFF, HI=A (original signed/unsigned value, unmodified).
  - Same 33-cycle latency.
- Signed overflow DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0x00000000. No trap.
- Operand magnitudes: |0x80000000| is treated as unsigned 0x80000000. Arithmetic is performed on 33-bit intermediates where needed.
- HI/LO hold their value between operations. Outputs come directly from registers.

Optional Feature:
- MDU_FAST_MUL_EN defined:
  - MULT/MULTU complete as a single-cycle combinational 32x32 multiply.
  - HI/LO are written at the posedge after start.
  - busy is high for exactly 1 cycle.
  - DIV/DIVU are unchanged (33 cycles).
- Not defined: all ops use the iterative 33-cycle path as above.

Test Plan:
- Reset then MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> busy high 33 cycles, then HI=0xFFFFFFFE, LO=0x00000001.
- MULT A=0xFFFFFFFD (-3) B=0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21).
- DIV A=0xFFFFFFF9 (-7) B=0x00000002 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIV A=0x80000000 B=0xFFFFFFFF -> LO=0x80000000, HI=0x00000000.
- DIVU A=0x00000064 B=0x00000000 -> LO=0xFFFFFFFF, HI=0x00000064, 33-cycle busy.
- Cycle 10 of a DIVU: assert start with new operands plus hi_wr -> both ignored, result unaffected. Then assert rst_n=0 during a second op -> busy=0, HI=LO=0 immediately, and a new start after release runs correctly. With MDU_FAST_MUL_EN: MULTU 3*5 -> busy 1 cycle, LO=0x0000000F.
